// File: rtl/keypad_scanner_4x4.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_4x4
// Brief    : 4x4 matrix keypad column scanner with debounce and valid/ack
//            key-code handshake towards the CPU bus.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clck_i,
    input  logic       rst_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ack_i,
    output logic       overrun_o
);

    localparam int               c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       c_DEB      = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAND = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [15:0]        r_snap;
    state_t             r_state;
    logic [3:0]         r_cand;
    logic [3:0]         r_cnt;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_overrun;

    logic               w_sample;
    logic               w_scan_done;
    logic [15:0]        w_snap_next;
    logic [1:0]         w_hits;
    logic [3:0]         w_code;
    logic               w_single;
    logic               w_none;
    state_t             w_state_nx;
    logic [3:0]         w_cand_nx;
    logic [3:0]         w_cnt_nx;
    logic [3:0]         w_cnt_inc;
    logic               w_press;
    logic [3:0]         w_press_code;

    assign w_sample    = (r_div == c_DIV_LAST);
    assign w_scan_done = w_sample && (r_col_idx == 2'd3);
    assign col_o       = ~(4'b0001 << r_col_idx);

    // Divider, column rotation and row synchronizer
    always_ff @(posedge clck_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div      <= '0;
            r_col_idx  <= 2'd0;
            r_row_meta <= 4'h0;
            r_row_sync <= 4'h0;
            r_snap     <= 16'h0000;
        end else begin
            r_row_meta <= row_i;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_snap    <= w_snap_next;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Snapshot bit col*4+row holds "pressed"; key code is row*4+col
    always_comb begin
        w_snap_next = r_snap;
        w_snap_next[{r_col_idx, 2'b00} +: 4] = ~r_row_sync;
        w_hits = 2'd0;
        w_code = 4'h0;
        for (int b = 0; b < 16; b++) begin
            if (w_snap_next[b]) begin
                if (w_hits != 2'd2) begin
                    w_hits = w_hits + 2'd1;
                end
                w_code = {b[1:0], b[3:2]};
            end
        end
        w_none   = (w_hits == 2'd0);
        w_single = (w_hits == 2'd1);
    end

    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clck_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cand  <= 4'h0;
            r_cnt   <= 4'h0;
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cand_nx    = r_cand;
        w_cnt_nx     = r_cnt;
        w_press      = 1'b0;
        w_press_code = r_cand;
        if (w_scan_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nx    = w_code;
                        w_cnt_nx     = 4'd1;
                        w_press_code = w_code;
                        if (c_DEB == 4'd1) begin
                            w_press    = 1'b1;
                            w_state_nx = ST_HELD;
                        end else begin
                            w_state_nx = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (w_single && (w_code == r_cand)) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc >= c_DEB) begin
                            w_press    = 1'b1;
                            w_state_nx = ST_HELD;
                        end
                    end else if (w_single) begin
                        w_cand_nx = w_code;
                        w_cnt_nx  = 4'd1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_none) begin
                        w_cnt_nx   = 4'd1;
                        w_state_nx = (c_DEB == 4'd1) ? ST_IDLE : ST_REL;
                    end
                end
                ST_REL: begin
                    if (w_none) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc >= c_DEB) begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_state_nx = ST_HELD;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // An ack coinciding with a press frees the slot, so the new code lands cleanly
    always_ff @(posedge clck_i or negedge rst_i) begin
        if (!rst_i) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_press) begin
            if (!r_key_valid || key_ack_i) begin
                r_key_code  <= w_press_code;
                r_key_valid <= 1'b1;
                r_overrun   <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (key_ack_i && r_key_valid) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign key_code_o  = r_key_code;
    assign key_valid_o = r_key_valid;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
Input-side peripheral companion to the 7-segment display scan logic. It drives the columns of a 4x4 matrix keypad with a rotating active-low strobe and reads the row lines back. It debounces the readings and presents one key code per press to the CPU bus through a valid/ack handshake. It sits beside the display peripheral in the memory-mapped I/O space.

Parameters:
SCAN_DIV, 50000, clock cycles each column stays strobed; must be at least 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; range 1..15

Ports:
clck_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-low reset
row_i  input  4  keypad rows, active-low, asynchronous to clck_i
col_o  output  4  column strobes, active-low, one-cold
key_code_o  output  4  accepted key code = row*4 + col
key_valid_o  output  1  key_code_o holds an unread key
key_ack_i  input  1  CPU read strobe, one cycle wide
overrun_o  output  1  sticky flag: a press was lost because valid was still set

Behaviour:
- Reset: all of the following apply whenever rst_i is low, independent of the clock:
  - col_o=4'b1110, key_code_o=0, key_valid_o=0, overrun_o=0.
  - Divider, column index, synchronizers, snapshot and FSM all cleared; FSM goes to IDLE.
  - Reset mid-scan or mid-debounce discards all partial state.
- Synchronizer: row_i passes through a 2-flop synchronizer. Only the synchronized value is used.
- Divider and column rotation:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the column index advances 0,1,2,3,0.
  - col_o = ~(1 << col_idx).
- Sampling:
  - Synchronized rows are sampled on the cycle where divider == SCAN_DIV-1, i.e. after settle plus synchronizer latency.
  - Each sample is stored inverted into a 16-bit snapshot at bits col_idx*4 + row.
- Scan completion: a full scan completes on the col 3 sample. The completed snapshot is then classified:
  - NONE: all zero.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set.
- Debounce FSM, evaluated once per completed scan:
  - IDLE:
    - SINGLE(c) -> CAND, cand=c, cnt=1; if DEBOUNCE_SCANS==1, go straight to the press event.
    - Else stay.
  - CAND:
    - SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESS event, then HELD.
    - SINGLE(other) -> restart CAND with the new code, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> REL, cnt=1.
    - Anything else stays HELD. No auto-repeat; a second key pressed while one is held is ignored.
  - REL:
    - NONE -> cnt+1; at DEBOUNCE_SCANS -> IDLE.
    - Any key -> back to HELD.
- Press event (registered, takes effect the cycle after the classifying scan completes):
  - key_valid_o==0: key_code_o=cand, key_valid_o=1.
  - key_valid_o==1 and key_ack_i==0: key_code_o is kept, overrun_o=1.
  - key_ack_i==1 in the same cycle: new code loads, valid stays 1, no overrun.
- Ack:
  - key_ack_i with no press event -> key_valid_o=0 and overrun_o=0 next cycle.
  - key_ack_i while valid==0 -> no effect.
- Latency from the first stable scan to valid: DEBOUNCE_SCANS full scans + 1 cycle.

Test Plan:
All cases use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so a full scan is 16 cycles.
1. Release rst_i with no key -> col_o cycles 1110,1101,1011,0111 every 4 clocks; key_valid_o stays 0; assert rst_i mid-cycle -> col_o=1110 immediately.
2. Hold row 2 low while col 1 is strobed, for 3 scans -> key_valid_o=1 with key_code_o=9; pulse key_ack_i -> key_valid_o=0 next cycle.
3. Press code 9 for 1 scan only, then release -> key_valid_o stays 0 (bounce rejected); alternate codes 9 and 5 each scan -> no event.
4. Press 9, do not ack, release for 2 scans, press 6 -> overrun_o=1, key_code_o still 9; ack -> key_valid_o=0, overrun_o=0.
5. Hold keys 3 and 12 together -> no event; hold 3 (accepted), then add 12 -> no second event until both are released for 2 scans.
6. Ack pulse coincident with the press-event cycle of code 6 while 9 is pending -> key_code_o=6, key_valid_o=1, overrun_o=0.
